mmu_ctx: RTL and testbench
==========================

Name: mmu_ctx

Overview:
- Second-generation page-map MMU: translates the top log2(NMMU) page bits of a VA via per-entry maps.
- Maps are indexed by {context, I/D, S/U, page}, for NCTX address-space contexts.
- Adds per-entry referenced/dirty tracking, sticky first-fault capture with overflow, readback of any entry, and a multi-cycle hardware flush sequencer (all contexts, or one context).
- Sits between core address generation and the bus, same position as the existing mmu.

Parameters:
- RV, 16, register/data width.
- VA, RV, virtual address width.
- PA, RV, physical address width.
- NMMU, 8, pages per map (power of 2).
- NCTX, 4, contexts (power of 2).
- Derived: UNTOUCHED = VA-$clog2(NMMU); IW = $clog2(NCTX)+2+$clog2(NMMU). Elaboration assert: (PA-UNTOUCHED)+IW+2 <= RV.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- access  in  1  valid memory access this cycle.
- is_pc, is_write, supmode, mmu_enable, mmu_i_proxy, mmu_d_proxy  in  1 each  as in the existing mmu.
- ctx  in  $clog2(NCTX)  current context.
- pcv, addrv  in  [VA-1:RV/16]  virtual addresses.
- addrp  out  [PA-1:RV/16]  physical address.
- mmu_miss_fault, mmu_prot_fault  out  1  faults.
- mmu_fault  in  1  core taking a fault this cycle.
- reg_write  in  1  register write strobe.
- reg_sel  in  2  register select: 0 entry, 1 fault status, 2 flush, 3 read index.
- reg_data  in  RV  write data.
- reg_read  out  RV  read data.
- busy  out  1  flush in progress.

Behaviour:
- Address select: taddr = (!is_write && is_pc) ? pcv : addrv.
- Entry select: sel = {ctx, is_pc|(supmode&mmu_i_proxy), supmode&~mmu_d_proxy, taddr[VA-1:UNTOUCHED]}.
- Lookup is combinational, zero latency.
  - Enable=0: addrp = {zero-extend taddr[VA-1:UNTOUCHED]}, then taddr[UNTOUCHED-1:RV/16].
  - Enable=1: addrp = {vtop[sel], offset}.
- Miss fault: mmu_enable & (!valid[sel] | busy).
- Prot fault: mmu_enable & is_write & valid[sel] & !busy & !writeable[sel].
- Reset values: valid, ref, dirty, all fault fields, rd_idx = 0; FSM IDLE; busy = 0. vtop and writeable are not reset.
- Entry write (reg_sel 0), with idx = reg_data[IW+1:2]:
  - vtop[idx] <= reg_data[RV-1 -: PA-UNTOUCHED]; valid <= bit0; writeable <= bit1.
  - ref[idx] and dirty[idx] <= 0.
  - Ignored while busy.
- Ref/dirty update, next edge, when access & mmu_enable & !busy & no fault:
  - ref[sel] <= 1.
  - if is_write, dirty[sel] <= 1.
  - If an entry write targets the same index in the same cycle, the entry write wins.
- Fault capture, on mmu_fault:
  - If !valid: capture addr = taddr[VA-1:UNTOUCHED], plus miss, write, ins; set valid.
  - Else: set ovf only.
- Fault status write (reg_sel 1) with bit0=1 clears valid/ovf. If mmu_fault arrives the same cycle, the clear is applied first, then the new fault is captured.
- Fault status read: {addr, zero pad, ovf, miss, ins, write, valid}.
- Read index (reg_sel 3):
  - Write sets rd_idx <= reg_data[IW+1:2].
  - Read returns {vtop[rd_idx], zero pad, dirty, ref, writeable, valid}.
- reg_read for sel 0/2 = {zeros, busy}.
- Flush FSM: IDLE -> FLUSH -> IDLE.
  - Start: reg_sel 2, bit0=1, while IDLE.
  - bit1=1 selects context mode: context = reg_data[$clog2(NCTX)+3:4].
  - FLUSH clears valid/ref/dirty of one entry per cycle using counter cnt.
  - Full mode: NCTX*4*NMMU cycles, indices 0..max.
  - Context mode: 4*NMMU cycles over {fctx, cnt}.
  - busy = 1 throughout FLUSH. Returns to IDLE the cycle after the last entry is cleared.
  - A start while busy is ignored.
- Asynchronous reset mid-flush: busy drops immediately and all valid bits read 0.

Optional Feature:
- MMU_DIRTY_EN defined:
  - Dirty bits are stored and updated as above.
  - A write hit to a clean writeable page behaves normally.
- Not defined:
  - No dirty storage; readback dirty bit = 0.
  - All other behaviour identical.

Decomposition:
- Package mmu_pkg holds:
  - reg_sel constants (REG_ENTRY, REG_FAULT, REG_FLUSH, REG_RDIDX).
  - Status bit offsets.
  - flush-state enum.
- One natural sub-module, mmu_flush_seq: FSM, counter, busy, and clear index/strobe outputs.

Test Plan:
- Reset, enable=0, addrv byte 0x6ABC -> addrp 0x6ABC, no faults.
- Write 0xA00F (ctx0 D-user page3 -> PPN5, W=1, V=1); enable, read 0x6ABC -> addrp 0xAABC.
  - Readback with rd_idx=3 -> ref=1.
  - Write access -> dirty=1 (0 without MMU_DIRTY_EN).
- Write entry with W=0; write-access the page -> prot_fault; mmu_fault -> status valid=1, write=1, addr=3.
  - Second mmu_fault -> ovf=1, addr unchanged.
  - Clear -> status 0.
- Full flush -> busy 128 cycles; access during flush -> miss_fault; afterwards all 128 entries read valid=0.
- Context-mode flush of ctx2 -> busy 32 cycles; ctx0 page3 still translates to 0xAABC.
- Assert reset_n low mid-flush (cycle 50) -> busy=0 asynchronously, FSM IDLE, all valid=0 after release.

Source files
------------

// File: rtl/mmu_pkg.sv
// ============================================================================
// mmu_pkg
// Shared constants for the context-aware page-map MMU: register selects,
// status/entry readback bit offsets and the flush sequencer state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mmu_pkg;

  // Register select codes
  localparam logic [1:0] REG_ENTRY = 2'd0;
  localparam logic [1:0] REG_FAULT = 2'd1;
  localparam logic [1:0] REG_FLUSH = 2'd2;
  localparam logic [1:0] REG_RDIDX = 2'd3;

  // Fault status readback bit offsets (captured page sits in the top bits)
  localparam int ST_VALID = 0;
  localparam int ST_WRITE = 1;
  localparam int ST_INS   = 2;
  localparam int ST_MISS  = 3;
  localparam int ST_OVF   = 4;

  // Entry readback bit offsets (vtop sits in the top bits)
  localparam int EN_VALID = 0;
  localparam int EN_WRITE = 1;
  localparam int EN_REF   = 2;
  localparam int EN_DIRTY = 3;

  // Flush sequencer states
  typedef enum logic [0:0] {
    FS_IDLE  = 1'b0,
    FS_FLUSH = 1'b1
  } flush_state_e;

endpackage

`default_nettype wire

// File: rtl/mmu_flush_seq.sv
// ============================================================================
// mmu_flush_seq
// Hardware flush sequencer: walks every map entry (or every entry of one
// context) clearing one entry per cycle, holding busy for the whole walk.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mmu_flush_seq
  import mmu_pkg::*;
#(
  parameter int IW = 7,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_ctx_mode,
  input  logic [CW-1:0] i_fctx,
  output logic          o_busy,
  output logic          o_clr,
  output logic [IW-1:0] o_clr_idx
);

  localparam int SUBW = IW - CW;
  localparam logic [IW-1:0] FULL_LAST = {IW{1'b1}};
  localparam logic [IW-1:0] CTX_LAST  = IW'((1 << SUBW) - 1);

  flush_state_e  r_state;
  logic          r_busy;
  logic          r_mode;
  logic [CW-1:0] r_fctx;
  logic [IW-1:0] r_cnt;
  logic          w_last;

  assign w_last    = r_mode ? (r_cnt == CTX_LAST) : (r_cnt == FULL_LAST);
  assign o_busy    = r_busy;
  assign o_clr     = r_busy;
  assign o_clr_idx = r_mode ? {r_fctx, r_cnt[SUBW-1:0]} : r_cnt;

  // Flush FSM: a start is only accepted from IDLE; one entry cleared per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FS_IDLE;
      r_busy  <= 1'b0;
      r_mode  <= 1'b0;
      r_fctx  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        FS_IDLE: begin
          if (i_start) begin
            r_state <= FS_FLUSH;
            r_busy  <= 1'b1;
            r_mode  <= i_ctx_mode;
            r_fctx  <= i_fctx;
            r_cnt   <= '0;
          end
        end
        FS_FLUSH: begin
          if (w_last) begin
            r_state <= FS_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + IW'(1);
          end
        end
        default: begin
          r_state <= FS_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmu_ctx.sv
// ============================================================================
// mmu_ctx
// Context-aware page-map MMU. Translates the top page bits of a virtual
// address through per-entry maps indexed by {context, I/D, S/U, page}, with
// referenced/dirty tracking, sticky first-fault capture, entry readback and a
// hardware flush sequencer.
// Optional: define MMU_DIRTY_EN to store and report per-entry dirty bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mmu_ctx
  import mmu_pkg::*;
#(
  parameter int RV   = 16,
  parameter int VA   = RV,
  parameter int PA   = RV,
  parameter int NMMU = 8,
  parameter int NCTX = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    access,
  input  logic                    is_pc,
  input  logic                    is_write,
  input  logic                    supmode,
  input  logic                    mmu_enable,
  input  logic                    mmu_i_proxy,
  input  logic                    mmu_d_proxy,
  input  logic [$clog2(NCTX)-1:0] ctx,
  input  logic [VA-1:RV/16]       pcv,
  input  logic [VA-1:RV/16]       addrv,
  output logic [PA-1:RV/16]       addrp,
  output logic                    mmu_miss_fault,
  output logic                    mmu_prot_fault,
  input  logic                    mmu_fault,
  input  logic                    reg_write,
  input  logic [1:0]              reg_sel,
  input  logic [RV-1:0]           reg_data,
  output logic [RV-1:0]           reg_read,
  output logic                    busy
);

  localparam int LSB       = RV / 16;
  localparam int PGW       = $clog2(NMMU);
  localparam int CW        = $clog2(NCTX);
  localparam int UNTOUCHED = VA - PGW;
  localparam int IW        = CW + 2 + PGW;
  localparam int NENT      = 1 << IW;
  localparam int PTW       = PA - UNTOUCHED;

  if ((PA - UNTOUCHED) + IW + 2 > RV) begin : g_bad_cfg
    $error("mmu_ctx: map entry fields do not fit in the register width");
  end

  // Map storage: vtop/writeable hold whatever software last wrote
  logic [PTW-1:0]  r_vtop [NENT];
  logic [NENT-1:0] r_wr;
  logic [NENT-1:0] r_valid;
  logic [NENT-1:0] r_ref;

  logic [IW-1:0]   r_rd_idx;
  logic            r_f_valid;
  logic            r_f_ovf;
  logic            r_f_miss;
  logic            r_f_ins;
  logic            r_f_write;
  logic [PGW-1:0]  r_f_addr;

  logic [VA-1:LSB]       w_taddr;
  logic [PGW-1:0]        w_page;
  logic [UNTOUCHED-1:LSB] w_off;
  logic                  w_ibit;
  logic                  w_sbit;
  logic [IW-1:0]         w_sel;
  logic                  w_busy;
  logic                  w_clr;
  logic [IW-1:0]         w_clr_idx;
  logic                  w_miss;
  logic                  w_prot;
  logic                  w_touch;
  logic                  w_ent_we;
  logic [IW-1:0]         w_ent_idx;
  logic                  w_fclr;
  logic                  w_fvalid_eff;
  logic                  w_fl_start;
  logic                  w_dirty_rd;
  logic [RV-1:0]         w_stat;
  logic [RV-1:0]         w_ent_rd;
  logic                  w_unused_ok;

  // Address and entry selection
  assign w_taddr = (!is_write && is_pc) ? pcv : addrv;
  assign w_page  = w_taddr[VA-1:UNTOUCHED];
  assign w_off   = w_taddr[UNTOUCHED-1:LSB];
  assign w_ibit  = is_pc | (supmode & mmu_i_proxy);
  assign w_sbit  = supmode & ~mmu_d_proxy;
  assign w_sel   = {ctx, w_ibit, w_sbit, w_page};

  // Zero-latency translation and fault generation; busy blocks all hits
  assign addrp          = mmu_enable ? {r_vtop[w_sel], w_off} : {PTW'(w_page), w_off};
  assign w_miss         = mmu_enable & (~r_valid[w_sel] | w_busy);
  assign w_prot         = mmu_enable & is_write & r_valid[w_sel] & ~w_busy & ~r_wr[w_sel];
  assign mmu_miss_fault = w_miss;
  assign mmu_prot_fault = w_prot;
  assign busy           = w_busy;

  assign w_touch      = access & mmu_enable & ~w_busy & ~w_miss & ~w_prot;
  assign w_ent_we     = reg_write & (reg_sel == REG_ENTRY) & ~w_busy;
  assign w_ent_idx    = reg_data[IW+1:2];
  assign w_fclr       = reg_write & (reg_sel == REG_FAULT) & reg_data[0];
  assign w_fvalid_eff = r_f_valid & ~w_fclr;
  assign w_fl_start   = reg_write & (reg_sel == REG_FLUSH) & reg_data[0];
  assign w_unused_ok  = ^reg_data;

  mmu_flush_seq #(
    .IW (IW),
    .CW (CW)
  ) u_flush (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_start    (w_fl_start),
    .i_ctx_mode (reg_data[1]),
    .i_fctx     (reg_data[CW+3:4]),
    .o_busy     (w_busy),
    .o_clr      (w_clr),
    .o_clr_idx  (w_clr_idx)
  );

  // Translation payload: written by software only, never reset
  always_ff @(posedge clk) begin
    if (w_ent_we) begin
      r_vtop[w_ent_idx] <= reg_data[RV-1 -: PTW];
      r_wr[w_ent_idx]   <= reg_data[1];
    end
  end

  // Valid/ref state: flush clears, accesses mark referenced, entry write wins last
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_ref   <= '0;
    end else begin
      if (w_clr) begin
        r_valid[w_clr_idx] <= 1'b0;
        r_ref[w_clr_idx]   <= 1'b0;
      end
      if (w_touch) begin
        r_ref[w_sel] <= 1'b1;
      end
      if (w_ent_we) begin
        r_valid[w_ent_idx] <= reg_data[0];
        r_ref[w_ent_idx]   <= 1'b0;
      end
    end
  end

`ifdef MMU_DIRTY_EN
  logic [NENT-1:0] r_dirty;

  // Dirty state: set by clean write hits, cleared by flush and entry writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dirty <= '0;
    end else begin
      if (w_clr) begin
        r_dirty[w_clr_idx] <= 1'b0;
      end
      if (w_touch && is_write) begin
        r_dirty[w_sel] <= 1'b1;
      end
      if (w_ent_we) begin
        r_dirty[w_ent_idx] <= 1'b0;
      end
    end
  end

  assign w_dirty_rd = r_dirty[r_rd_idx];
`else
  assign w_dirty_rd = 1'b0;
`endif

  // Readback index register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_idx <= '0;
    end else if (reg_write && (reg_sel == REG_RDIDX)) begin
      r_rd_idx <= reg_data[IW+1:2];
    end
  end

  // Sticky first-fault capture; a same-cycle clear makes room for the new fault
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f_valid <= 1'b0;
      r_f_ovf   <= 1'b0;
      r_f_miss  <= 1'b0;
      r_f_ins   <= 1'b0;
      r_f_write <= 1'b0;
      r_f_addr  <= '0;
    end else begin
      if (w_fclr) begin
        r_f_valid <= 1'b0;
        r_f_ovf   <= 1'b0;
        r_f_miss  <= 1'b0;
        r_f_ins   <= 1'b0;
        r_f_write <= 1'b0;
        r_f_addr  <= '0;
      end
      if (mmu_fault) begin
        if (!w_fvalid_eff) begin
          r_f_valid <= 1'b1;
          r_f_addr  <= w_page;
          r_f_miss  <= w_miss;
          r_f_ins   <= w_ibit;
          r_f_write <= is_write;
        end else begin
          r_f_ovf <= 1'b1;
        end
      end
    end
  end

  // Readback word assembly
  always_comb begin
    w_stat                = '0;
    w_stat[RV-1 -: PGW]   = r_f_addr;
    w_stat[ST_OVF]        = r_f_ovf;
    w_stat[ST_MISS]       = r_f_miss;
    w_stat[ST_INS]        = r_f_ins;
    w_stat[ST_WRITE]      = r_f_write;
    w_stat[ST_VALID]      = r_f_valid;
    w_ent_rd              = '0;
    w_ent_rd[RV-1 -: PTW] = r_vtop[r_rd_idx];
    w_ent_rd[EN_DIRTY]    = w_dirty_rd;
    w_ent_rd[EN_REF]      = r_ref[r_rd_idx];
    w_ent_rd[EN_WRITE]    = r_wr[r_rd_idx];
    w_ent_rd[EN_VALID]    = r_valid[r_rd_idx];
  end

  // Register read mux
  always_comb begin
    case (reg_sel)
      REG_FAULT: reg_read = w_stat;
      REG_RDIDX: reg_read = w_ent_rd;
      default:   reg_read = {{(RV-1){1'b0}}, w_busy};
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mmu_ctx.sv
// ============================================================================
// tb_mmu_ctx
// Directed bench for mmu_ctx with a behavioural map model and a per-cycle
// comparison of every output against it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mmu_ctx;

`ifdef MMU_DIRTY_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif
  localparam int NENT    = 128;
  localparam int PER_CTX = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        access, is_pc, is_write, supmode, mmu_enable, mmu_i_proxy, mmu_d_proxy;
  logic [1:0]  ctx;
  logic [15:1] pcv, addrv, addrp;
  logic        mmu_miss_fault, mmu_prot_fault, mmu_fault;
  logic        reg_write;
  logic [1:0]  reg_sel;
  logic [15:0] reg_data, reg_read;
  logic        busy;

  mmu_ctx dut (
    .clk(clk), .reset_n(reset_n), .access(access), .is_pc(is_pc), .is_write(is_write),
    .supmode(supmode), .mmu_enable(mmu_enable), .mmu_i_proxy(mmu_i_proxy),
    .mmu_d_proxy(mmu_d_proxy), .ctx(ctx), .pcv(pcv), .addrv(addrv), .addrp(addrp),
    .mmu_miss_fault(mmu_miss_fault), .mmu_prot_fault(mmu_prot_fault), .mmu_fault(mmu_fault),
    .reg_write(reg_write), .reg_sel(reg_sel), .reg_data(reg_data), .reg_read(reg_read),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit m_run  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_vtop [NENT];
  bit m_known[NENT], m_w[NENT], m_v[NENT], m_r[NENT], m_d[NENT];
  bit f_v, f_o, f_m, f_i, f_w;
  int f_a, m_rdidx, m_left, m_pos, m_fctx;
  bit m_fmode;

  function automatic int t_addr();
    return (!is_write && is_pc) ? int'(pcv) : int'(addrv);
  endfunction

  function automatic int cur_idx();
    int ib, sb;
    ib = (is_pc || (supmode && mmu_i_proxy)) ? 1 : 0;
    sb = (supmode && !mmu_d_proxy) ? 1 : 0;
    return ctx * 32 + ib * 16 + sb * 8 + (t_addr() >> 12);
  endfunction

  function automatic bit exp_miss();
    return mmu_enable && (!m_v[cur_idx()] || m_left > 0);
  endfunction

  function automatic bit exp_prot();
    int i = cur_idx();
    return mmu_enable && is_write && m_v[i] && (m_left == 0) && !m_w[i];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NENT; i++) begin
        m_v[i] = 0; m_r[i] = 0; m_d[i] = 0;
      end
      f_v = 0; f_o = 0; f_m = 0; f_i = 0; f_w = 0; f_a = 0;
      m_rdidx = 0; m_left = 0; m_pos = 0; m_fctx = 0; m_fmode = 0;
    end else begin
      int  i, e;
      bit  was_busy, mi, pr;
      was_busy = (m_left > 0);
      i  = cur_idx();
      mi = exp_miss();
      pr = exp_prot();
      if (was_busy) begin
        e = m_fmode ? (m_fctx * PER_CTX + m_pos) : m_pos;
        m_v[e] = 0; m_r[e] = 0; m_d[e] = 0;
        m_pos++;
        m_left--;
      end else if (reg_write && reg_sel == 2'd2 && reg_data[0]) begin
        m_fmode = reg_data[1];
        m_fctx  = int'(reg_data[5:4]);
        m_left  = m_fmode ? PER_CTX : NENT;
        m_pos   = 0;
      end
      if (access && mmu_enable && !was_busy && !mi && !pr) begin
        m_r[i] = 1;
        if (DIRTY_EN && is_write) m_d[i] = 1;
      end
      if (reg_write && reg_sel == 2'd0 && !was_busy) begin
        e = (int'(reg_data) >> 2) % NENT;
        m_vtop[e] = int'(reg_data) >> 13;
        m_known[e] = 1; m_w[e] = reg_data[1]; m_v[e] = reg_data[0];
        m_r[e] = 0; m_d[e] = 0;
      end
      if (reg_write && reg_sel == 2'd1 && reg_data[0]) begin
        f_v = 0; f_o = 0; f_m = 0; f_i = 0; f_w = 0; f_a = 0;
      end
      if (mmu_fault) begin
        if (!f_v) begin
          f_v = 1; f_a = t_addr() >> 12; f_m = mi; f_w = is_write;
          f_i = is_pc || (supmode && mmu_i_proxy);
        end else begin
          f_o = 1;
        end
      end
      if (reg_write && reg_sel == 2'd3) m_rdidx = (int'(reg_data) >> 2) % NENT;
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (reset_n && m_run) begin
      int i, ex, mask;
      i = cur_idx();
      chk("busy", busy, (m_left > 0) ? 1 : 0);
      chk("miss", mmu_miss_fault, exp_miss());
      chk("prot", mmu_prot_fault, exp_prot());
      if (!mmu_enable)
        chk("addrp_pass", addrp, t_addr());
      else if (m_known[i])
        chk("addrp_xlat", addrp, m_vtop[i] * 4096 + (t_addr() % 4096));
      mask = 16'hFFFF;
      case (reg_sel)
        2'd1: ex = f_a * 8192 + f_o * 16 + f_m * 8 + f_i * 4 + f_w * 2 + f_v;
        2'd3: begin
          ex = m_vtop[m_rdidx] * 8192 + (DIRTY_EN ? m_d[m_rdidx] * 8 : 0)
               + m_r[m_rdidx] * 4 + m_w[m_rdidx] * 2 + m_v[m_rdidx];
          if (!m_known[m_rdidx]) mask = 16'h1FFD;
        end
        default: ex = (m_left > 0) ? 1 : 0;
      endcase
      chk("reg_read", int'(reg_read) & mask, ex & mask);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] s, input logic [15:0] d);
    reg_write = 1'b1; reg_sel = s; reg_data = d;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] s, output logic [15:0] d);
    reg_sel = s;
    #1;
    d = reg_read;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic check_all_invalid(input string name);
    logic [15:0] d;
    for (int i = 0; i < NENT; i++) begin
      reg_wr(2'd3, 16'(i << 2));
      rd(2'd3, d);
      chk(name, d[0], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int n;
    reset_n = 0; access = 0; is_pc = 0; is_write = 0; supmode = 0; mmu_enable = 0;
    mmu_i_proxy = 0; mmu_d_proxy = 0; ctx = 0; pcv = '0; addrv = '0; mmu_fault = 0;
    reg_write = 0; reg_sel = 0; reg_data = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1; m_run = 1;

    // Reset state
    chk("rst_busy", busy, 0);
    rd(2'd1, d); chk("rst_status", d, 0);
    rd(2'd3, d); chk("rst_entry0_valid", d[0], 0);

    // Pass-through with translation disabled
    d = 16'h6ABC; addrv = d[15:1]; #1;
    chk("pass_addrp", {addrp, 1'b0}, 16'h6ABC);
    chk("pass_miss", mmu_miss_fault, 0);
    chk("pass_prot", mmu_prot_fault, 0);

    // Map ctx0 D-user page 3 -> PPN 5, writeable, valid
    reg_wr(2'd0, 16'hA00F);
    mmu_enable = 1; access = 1; #1;
    chk("xlat_addrp", {addrp, 1'b0}, 16'hAABC);
    chk("xlat_miss", mmu_miss_fault, 0);
    tick(); access = 0;
    reg_wr(2'd3, 16'h000C); rd(2'd3, d); chk("ref_set", d, 16'hA007);
    is_write = 1; access = 1; tick(); access = 0; is_write = 0;
    rd(2'd3, d); chk("dirty_set", d, DIRTY_EN ? 16'hA00F : 16'hA007);

    // Protection fault and sticky capture
    reg_wr(2'd0, 16'hA00D);
    is_write = 1; access = 1; #1;
    chk("prot_fault", mmu_prot_fault, 1);
    chk("prot_nomiss", mmu_miss_fault, 0);
    mmu_fault = 1; tick(); mmu_fault = 0; access = 0; is_write = 0;
    rd(2'd1, d); chk("fault_first", d, 16'h6003);
    d = 16'hA000; addrv = d[15:1]; mmu_fault = 1; tick(); mmu_fault = 0;
    rd(2'd1, d); chk("fault_ovf", d, 16'h6013);
    reg_wr(2'd1, 16'h0001); rd(2'd1, d); chk("fault_clear", d, 0);

    // Full flush
    reg_wr(2'd0, 16'hA00F);
    d = 16'h6ABC; addrv = d[15:1];
    reg_wr(2'd2, 16'h0001);
    chk("flush_miss", mmu_miss_fault, 1);
    count_busy(n); chk("full_flush_len", n, 128);
    check_all_invalid("full_flush_valid");

    // Context-mode flush of ctx2 leaves ctx0 intact
    reg_wr(2'd0, 16'hA00F);
    reg_wr(2'd0, 16'hE10F);
    reg_wr(2'd2, 16'h0023);
    count_busy(n); chk("ctx_flush_len", n, 32);
    reg_wr(2'd3, 16'h010C); rd(2'd3, d); chk("ctx2_flushed", d[0], 0);
    reg_wr(2'd3, 16'h000C); rd(2'd3, d); chk("ctx0_kept", d, 16'hA003);
    #1; chk("ctx0_xlat", {addrp, 1'b0}, 16'hAABC);

    // Asynchronous reset in the middle of a full flush
    reg_wr(2'd0, 16'h2193);
    reg_wr(2'd2, 16'h0001);
    repeat (50) tick();
    chk("midflush_busy", busy, 1);
    #2 reset_n = 0;
    #1 chk("async_busy_drop", busy, 0);
    @(posedge clk); #1 reset_n = 1;
    check_all_invalid("reset_valid");
    reg_wr(2'd2, 16'h0013);
    count_busy(n); chk("post_reset_flush_len", n, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
